// File: rtl/fib_sequencer_if.sv
// Wishbone slave port bundle for the Fibonacci run controller.
interface fib_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/fib_sequencer.sv
// Fibonacci run controller: Wishbone-configured prescaler, clear/step strobes,
// value sampling with wrap detection and a completion interrupt.
module fib_sequencer #(
    parameter int unsigned WIDTH     = 30,
    parameter int unsigned DIV_WIDTH = 36,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             reset_n,
    fib_sequencer_if.slave   wbs,
    output logic             fib_clear_o,
    output logic             fib_step_o,
    input  logic [WIDTH-1:0] fib_value_i,
    output logic             irq_o
);

    localparam int unsigned STEP_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q;
    logic [2:0]           rate_q;
    logic                 cont_q, soo_q;
    logic [STEP_W-1:0]    count_q, steps_q;
    logic                 done_q, ovf_q, done_d, ovf_d, irq_q;
    logic [WIDTH-1:0]     value_q;
    logic                 first_q;
    logic                 samp_q;
    logic                 step_q, clear_q;
    logic                 ack_q;
    logic [31:0]          dat_q;

    logic                 req_c, acc_c, wr_c;
    logic                 wr_ctrl_c, wr_count_c, w1c_c;
    logic                 start_c, stop_c;
    logic                 busy_c, limit_c, issue_c, ovf_hit_c, tick_c;
    logic [DIV_WIDTH-1:0] tick_mask_c;
    logic [31:0]          rdata_c;
    logic                 unused_bits;

    // Bus decode; one access per two cycles because ack blocks the next accept.
    assign req_c      = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc_c      = req_c & ~ack_q;
    assign wr_c       = acc_c & wbs.wbs_we_i;
    assign wr_ctrl_c  = wr_c & (wbs.wbs_adr_i[3:2] == REG_CTRL) & wbs.wbs_sel_i[0];
    assign wr_count_c = wr_c & (wbs.wbs_adr_i[3:2] == REG_COUNT);
    assign w1c_c      = wr_c & (wbs.wbs_adr_i[3:2] == REG_STATUS) & wbs.wbs_sel_i[0];
    assign stop_c     = wr_ctrl_c & wbs.wbs_dat_i[1];
    assign start_c    = wr_ctrl_c & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[1];
    assign unused_bits = &{1'b0, wbs.wbs_dat_i[31:16], wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2]};

    assign busy_c  = (state_q == S_CLEAR) | (state_q == S_RUN);
    assign limit_c = ~cont_q & (steps_q >= count_q);

    // Prescaler tick: the low 8*rate bits all ones, every cycle at rate 0.
    always_comb begin
        tick_mask_c = '1;
        if (rate_q == 3'd0) begin
            tick_mask_c = '0;
        end else if (rate_q < 3'd5) begin
            tick_mask_c = ~({DIV_WIDTH{1'b1}} << {rate_q, 3'b000});
        end
        tick_c = &(div_q | ~tick_mask_c);
    end

    // Step issue; with stop_on_ovf the next step waits until the previous one is compared.
    assign issue_c = (state_q == S_RUN) & tick_c & ~stop_c & ~limit_c
                   & ~(soo_q & (step_q | samp_q));

    // Wrap detection on the sample following a step, skipping the first sample of a run.
    assign ovf_hit_c = samp_q & ~first_q & (state_q != S_CLEAR) & (fib_value_i < value_q);

    // State register.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_c) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (stop_c)                              state_d = S_IDLE;
                else if (!cont_q && count_q == '0)       state_d = S_DONE;
                else                                     state_d = S_RUN;
            end
            S_RUN: begin
                if (stop_c)                              state_d = S_IDLE;
                else if (soo_q && ovf_hit_c)             state_d = S_DONE;
                else if (limit_c && !step_q)             state_d = S_DONE;
            end
            default: begin
                if (start_c) state_d = S_CLEAR;
            end
        endcase
    end

    // Sticky status flags; a hardware set wins over a same-cycle W1C.
    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        if (w1c_c && wbs.wbs_dat_i[1]) done_d = 1'b0;
        if (w1c_c && wbs.wbs_dat_i[2]) ovf_d  = 1'b0;
        if (state_d == S_DONE && state_q != S_DONE) done_d = 1'b1;
        if (ovf_hit_c) ovf_d = 1'b1;
    end

    // Register read mux.
    always_comb begin
        rdata_c = '0;
        case (wbs.wbs_adr_i[3:2])
            REG_CTRL:   rdata_c = {25'd0, rate_q, soo_q, cont_q, 2'b00};
            REG_COUNT:  rdata_c = {16'd0, count_q};
            REG_STATUS: rdata_c = {steps_q, 13'd0, ovf_q, done_q, busy_c};
            default:    rdata_c = 32'(value_q);
        endcase
    end

    // Configuration registers.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cont_q  <= 1'b0;
            soo_q   <= 1'b0;
            rate_q  <= 3'd0;
            count_q <= '0;
        end else begin
            if (wr_ctrl_c) begin
                cont_q <= wbs.wbs_dat_i[2];
                soo_q  <= wbs.wbs_dat_i[3];
                rate_q <= wbs.wbs_dat_i[6:4];
            end
            if (wr_count_c && wbs.wbs_sel_i[0]) count_q[7:0]  <= wbs.wbs_dat_i[7:0];
            if (wr_count_c && wbs.wbs_sel_i[1]) count_q[15:8] <= wbs.wbs_dat_i[15:8];
        end
    end

    // Status flags and interrupt.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
            irq_q  <= done_d | ovf_d;
        end
    end

    // Prescaler, step counter, strobes and value sampling.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            steps_q <= '0;
            value_q <= '0;
            first_q <= 1'b1;
            samp_q  <= 1'b0;
            step_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= (state_d == S_CLEAR);
            step_q  <= issue_c;
            if (state_q == S_CLEAR) begin
                div_q   <= '0;
                steps_q <= '0;
                value_q <= '0;
                first_q <= 1'b1;
                samp_q  <= 1'b0;
            end else begin
                div_q  <= div_q + DIV_WIDTH'(1);
                samp_q <= step_q;
                if (issue_c) steps_q <= steps_q + STEP_W'(1);
                if (samp_q) begin
                    value_q <= fib_value_i;
                    first_q <= 1'b0;
                end
            end
        end
    end

    // Wishbone acknowledge and read data, zero outside the ack cycle.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc_c;
            dat_q <= acc_c ? rdata_c : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign fib_clear_o   = clear_q;
    assign fib_step_o    = step_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer with an 8-bit Fibonacci datapath model on the strobes.
module tb_fib_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fib_clear, fib_step, irq;
    logic [7:0] fib_value;
    logic [7:0] fa = 8'd0;
    logic [7:0] fb = 8'd1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int step_cyc[$];
    int clear_cyc[$];

    fib_sequencer_if bus ();

    fib_sequencer #(.WIDTH(8), .DIV_WIDTH(36), .BASE_ADDR(BASE)) dut (
        .wb_clk_i    (clk),
        .reset_n     (reset_n),
        .wbs         (bus),
        .fib_clear_o (fib_clear),
        .fib_step_o  (fib_step),
        .fib_value_i (fib_value),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Datapath stand-in: clear to (0,1), step advances the pair.
    always @(posedge clk) begin
        if (fib_clear) begin
            fa <= 8'd0;
            fb <= 8'd1;
        end else if (fib_step) begin
            fa <= fb;
            fb <= fa + fb;
        end
    end
    assign fib_value = fa;

    // Strobe log.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && fib_step === 1'b1)  step_cyc.push_back(cyc_n);
        if (reset_n === 1'b1 && fib_clear === 1'b1) clear_cyc.push_back(cyc_n);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int fib_mod(input int n);
        int a, b, t;
        a = 0;
        b = 1;
        for (int k = 0; k < n; k++) begin
            t = (a + b) % 256;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic wrap_model(output int steps, output int val);
        int a, b, t, prev;
        a = 0; b = 1; prev = 0; steps = 0;
        for (int k = 1; k < 1000; k++) begin
            t = (a + b) % 256;
            a = b;
            b = t;
            if (k > 1 && a < prev) begin
                steps = k;
                break;
            end
            prev = a;
        end
        val = a;
    endtask

    task automatic bus_idle();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = '0;
    endtask

    task automatic wb_access(input logic [31:0] off, input logic we, input logic [31:0] d,
                             input logic [3:0] sel, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd = '0;
        bus.wbs_adr_i = BASE + off;
        bus.wbs_dat_i = d;
        bus.wbs_sel_i = sel;
        bus.wbs_we_i  = we;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.wbs_ack_o;
            rd  = bus.wbs_dat_o;
        end
        bus_idle();
        if (!got) begin
            n_fail++;
            $display("FAIL wb_ack timeout off=%0h", off);
        end
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(off, 1'b1, d, sel, dummy);
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] rd);
        wb_access(off, 1'b0, '0, 4'hf, rd);
    endtask

    task automatic wait_irq(input int max_cyc);
        int i;
        i = 0;
        while (irq !== 1'b1 && i < max_cyc) begin
            @(posedge clk); #1;
            i++;
        end
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq timeout after %0d cycles", max_cyc);
        end
    endtask

    task automatic wait_steps(input int n, input int max_cyc);
        int i;
        i = 0;
        while (step_cyc.size() < n && i < max_cyc) begin
            @(posedge clk); #1;
            i++;
        end
        if (step_cyc.size() < n) begin
            n_fail++;
            $display("FAIL step timeout got=%0d want=%0d", step_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] offs [4];
        offs = '{32'h0, 32'h4, 32'h8, 32'hC};
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.wbs_ack_o, bus.wbs_dat_o, fib_clear, fib_step, irq} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got ack=%b dat=%h clr=%b step=%b irq=%b want all 0",
                     bus.wbs_ack_o, bus.wbs_dat_o, fib_clear, fib_step, irq);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (offs[i]) begin
            wb_read(offs[i], rd);
            n_checks++;
            if (rd !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_reg off=%0h got=%h want=0", offs[i], rd);
            end
        end
        n_checks++;
        if (irq !== 1'b0 || step_cyc.size() != 0 || clear_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle irq=%b steps=%0d clears=%0d want 0/0/0",
                     irq, step_cyc.size(), clear_cyc.size());
        end
    endtask

    task automatic test_count_run(input int cnt);
        logic [31:0] rd;
        logic        ok;
        step_cyc.delete();
        clear_cyc.delete();
        wb_write(32'h4, 32'(cnt), 4'hf);
        wb_write(32'h0, 32'h1, 4'h1);
        wait_irq(300);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (clear_cyc.size() != 1 || step_cyc.size() != cnt) begin
            n_fail++;
            $display("FAIL run_pulses cnt=%0d got clears=%0d steps=%0d want 1/%0d",
                     cnt, clear_cyc.size(), step_cyc.size(), cnt);
        end
        ok = (clear_cyc.size() == 1 && step_cyc.size() > 0 && step_cyc[0] > clear_cyc[0]);
        for (int i = 1; i < step_cyc.size(); i++)
            if (step_cyc[i] != step_cyc[i-1] + 1) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL run_consecutive cnt=%0d got non-consecutive or misordered steps want consecutive after clear", cnt);
        end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'(fib_mod(cnt))) begin
            n_fail++;
            $display("FAIL run_value cnt=%0d got=%0d want=%0d", cnt, rd, fib_mod(cnt));
        end
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== {16'(cnt), 16'h0002} || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL run_status cnt=%0d got=%h irq=%b want=%h irq=1", cnt, rd, irq, {16'(cnt), 16'h0002});
        end
        wb_write(32'h8, 32'h2, 4'hf);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq got=%b want=0", irq);
        end
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== {16'(cnt), 16'h0000}) begin
            n_fail++;
            $display("FAIL w1c_status got=%h want=%h", rd, {16'(cnt), 16'h0000});
        end
    endtask

    task automatic test_count_lanes();
        logic [31:0] d1, d2, rd;
        logic [3:0]  sel;
        logic [15:0] exp;
        for (int it = 0; it < 3; it++) begin
            d1  = $urandom;
            d2  = $urandom;
            sel = 4'($urandom_range(0, 15));
            exp = d1[15:0];
            if (sel[0]) exp[7:0]  = d2[7:0];
            if (sel[1]) exp[15:8] = d2[15:8];
            wb_write(32'h4, d1, 4'hf);
            wb_write(32'h4, d2, sel);
            wb_read(32'h4, rd);
            n_checks++;
            if (rd !== {16'd0, exp}) begin
                n_fail++;
                $display("FAIL count_lanes sel=%b got=%h want=%h", sel, rd, {16'd0, exp});
            end
        end
    endtask

    task automatic test_rate1();
        logic [31:0] rd;
        logic        ok;
        step_cyc.delete();
        clear_cyc.delete();
        wb_write(32'h4, 32'd3, 4'hf);
        wb_write(32'h0, 32'h11, 4'h1);
        wait_steps(2, 1000);
        repeat (5) @(posedge clk);
        #1;
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0002_0001) begin
            n_fail++;
            $display("FAIL rate1_midrun got=%h want=00020001", rd);
        end
        wait_irq(1000);
        ok = (step_cyc.size() == 3);
        for (int i = 1; i < step_cyc.size(); i++)
            if (step_cyc[i] - step_cyc[i-1] != 256) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rate1_spacing got %0d steps, want 3 steps 256 cycles apart", step_cyc.size());
        end
        repeat (2) @(posedge clk);
        #1;
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0003_0002) begin
            n_fail++;
            $display("FAIL rate1_status got=%h want=00030002", rd);
        end
        wb_write(32'h8, 32'h2, 4'hf);
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        int          exp_steps, exp_val;
        wrap_model(exp_steps, exp_val);
        step_cyc.delete();
        clear_cyc.delete();
        wb_write(32'h0, 32'h0D, 4'h1);
        wait_irq(300);
        repeat (3) @(posedge clk);
        #1;
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'(exp_val)) begin
            n_fail++;
            $display("FAIL wrap_value got=%0d want=%0d", rd, exp_val);
        end
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== {16'(exp_steps), 16'h0006}) begin
            n_fail++;
            $display("FAIL wrap_status got=%h want=%h", rd, {16'(exp_steps), 16'h0006});
        end
        n_checks++;
        if (step_cyc.size() != exp_steps) begin
            n_fail++;
            $display("FAIL wrap_pulses got=%0d want=%0d", step_cyc.size(), exp_steps);
        end
        wb_write(32'h8, 32'h6, 4'hf);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_w1c irq got=%b want=0", irq);
        end
    endtask

    task automatic test_stop();
        logic [31:0] rd;
        step_cyc.delete();
        clear_cyc.delete();
        wb_write(32'h4, 32'd20, 4'hf);
        wb_write(32'h0, 32'h11, 4'h1);
        wait_steps(5, 1500);
        repeat (10) @(posedge clk);
        #1;
        wb_write(32'h0, 32'h12, 4'h1);
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'h0005_0000) begin
            n_fail++;
            $display("FAIL stop_status got=%h want=00050000", rd);
        end
        wb_read(32'hC, rd);
        n_checks++;
        if (rd !== 32'(fib_mod(5))) begin
            n_fail++;
            $display("FAIL stop_value got=%0d want=%0d", rd, fib_mod(5));
        end
        repeat (300) @(posedge clk);
        #1;
        n_checks++;
        if (step_cyc.size() != 5) begin
            n_fail++;
            $display("FAIL stop_quiet got=%0d steps want=5", step_cyc.size());
        end
        clear_cyc.delete();
        wb_write(32'h0, 32'h13, 4'h1);
        repeat (5) @(posedge clk);
        #1;
        wb_read(32'h8, rd);
        n_checks++;
        if (clear_cyc.size() != 0 || rd !== 32'h0005_0000) begin
            n_fail++;
            $display("FAIL start_stop got clears=%0d status=%h want 0/00050000", clear_cyc.size(), rd);
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] rd;
        step_cyc.delete();
        clear_cyc.delete();
        wb_write(32'h4, 32'd3, 4'hf);
        wb_write(32'h0, 32'h11, 4'h1);
        wait_steps(1, 600);
        wb_write(32'h0, 32'h11, 4'h1);
        wait_irq(1200);
        repeat (2) @(posedge clk);
        #1;
        wb_read(32'h8, rd);
        n_checks++;
        if (clear_cyc.size() != 1 || step_cyc.size() != 3 || rd !== 32'h0003_0002) begin
            n_fail++;
            $display("FAIL busy_start got clears=%0d steps=%0d status=%h want 1/3/00030002",
                     clear_cyc.size(), step_cyc.size(), rd);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        step_cyc.delete();
        clear_cyc.delete();
        wb_write(32'h4, 32'd20, 4'hf);
        wb_write(32'h0, 32'h01, 4'h1);
        wait_steps(3, 100);
        @(negedge clk);
        n_checks++;
        if (fib_step !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre got step=%b irq=%b want 1/1", fib_step, irq);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.wbs_ack_o, bus.wbs_dat_o, fib_clear, fib_step, irq} !== 36'd0) begin
            n_fail++;
            $display("FAIL async_reset got ack=%b dat=%h clr=%b step=%b irq=%b want all 0",
                     bus.wbs_ack_o, bus.wbs_dat_o, fib_clear, fib_step, irq);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wb_read(32'h8, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_status got=%h want=0", rd);
        end
        wb_read(32'h4, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_count got=%h want=0", rd);
        end
    endtask

    task automatic test_bus_handshake();
        logic [31:0] r;
        logic        exp_ack;
        int          acks;
        r = 32'($urandom_range(1, 65535));
        wb_write(32'h4, r, 4'hf);
        @(posedge clk);
        #1;
        bus.wbs_adr_i = BASE + 32'h4;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'hf;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            exp_ack = (i % 2 == 0);
            n_checks++;
            if (bus.wbs_ack_o !== exp_ack || bus.wbs_dat_o !== (exp_ack ? r : 32'd0)) begin
                n_fail++;
                $display("FAIL held_ack cyc=%0d got ack=%b dat=%h want ack=%b dat=%h",
                         i, bus.wbs_ack_o, bus.wbs_dat_o, exp_ack, exp_ack ? r : 32'd0);
            end
        end
        bus_idle();
        @(posedge clk);
        #1;
        bus.wbs_adr_i = BASE + 32'h10;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o === 1'b1) acks++;
        end
        bus_idle();
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL out_of_window got %0d acks want 0", acks);
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_count_run(10);
        for (int it = 0; it < 3; it++) test_count_run($urandom_range(1, 13));
        test_count_lanes();
        test_rate1();
        test_wrap();
        test_stop();
        test_start_while_busy();
        test_async_reset();
        test_bus_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
